// File: rtl/uno_hand.sv
// Per-player UNO hand buffer: draws cards from the deck, validates plays against the
// discard top and returns played cards. Define HAND_COLOR_CNT_EN to add per-color counts.
module uno_hand #(
    parameter int unsigned MAX_CARDS = 32,
    parameter int unsigned IDX_W     = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [2:0]       i_req_draw,
    output logic [2:0]       o_draw,
    input  logic             i_drawn,
    input  logic [5:0]       i_card,
    input  logic             i_deck_done,
    input  logic             i_play,
    input  logic [IDX_W-1:0] i_play_idx,
    input  logic [5:0]       i_top_card,
    output logic             o_insert,
    output logic [5:0]       o_prev_card,
    output logic             o_play_ok,
    output logic             o_play_err,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [5:0]       o_rd_card,
    output logic [IDX_W-1:0] o_count,
    output logic             o_busy,
    output logic             o_overflow
`ifdef HAND_COLOR_CNT_EN
    ,
    output logic [4*IDX_W-1:0] o_color_cnt
`endif
);

    localparam logic [5:0]       EMPTY = 6'h3F;
    localparam logic [IDX_W-1:0] CAP   = IDX_W'(MAX_CARDS);
    localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_CHECK,
        S_INSERT
    } state_t;

    state_t           state, state_nxt;
    logic [5:0]       slots [MAX_CARDS];
    logic [IDX_W-1:0] count;
    logic [IDX_W-1:0] idx;
    logic [2:0]       need;
    logic [2:0]       code;
    logic [5:0]       prev_card;
    logic             overflow;

    logic             req_valid;
    logic [2:0]       req_need;
    logic [5:0]       sel_card;
    logic [5:0]       last_card;
    logic [5:0]       rd_card;
    logic [IDX_W-1:0] count_m1;
    logic             full;
    logic             in_range;
    logic             legal_card;
    logic             accept;
    logic             store;

    // Non-one-hot draw requests are ignored entirely.
    always_comb begin
        req_valid = 1'b1;
        req_need  = 3'd0;
        case (i_req_draw)
            3'b001:  req_need = 3'd1;
            3'b010:  req_need = 3'd2;
            3'b100:  req_need = 3'd4;
            default: req_valid = 1'b0;
        endcase
    end

    assign count_m1 = count - ONE;
    assign full     = (count == CAP);
    assign in_range = (idx < count);

    always_comb begin
        sel_card  = EMPTY;
        last_card = EMPTY;
        rd_card   = EMPTY;
        for (int unsigned i = 0; i < MAX_CARDS; i++) begin
            if (IDX_W'(i) == idx)
                sel_card = slots[i];
            if (IDX_W'(i) == count_m1)
                last_card = slots[i];
            if ((IDX_W'(i) == i_rd_idx) && (i_rd_idx < count))
                rd_card = slots[i];
        end
    end

    always_comb begin
        legal_card = (sel_card[3:0] == 4'd13) || (sel_card[3:0] == 4'd14) ||
                     (sel_card[5:4] == i_top_card[5:4]) ||
                     (sel_card[3:0] == i_top_card[3:0]);
        accept     = in_range && legal_card;
    end

    assign store = (state == S_DRAW) && i_drawn && !full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid)
                    state_nxt = S_DRAW;
                else if (i_play)
                    state_nxt = S_CHECK;
            end
            S_DRAW: begin
                if (i_drawn && (need == 3'd1))
                    state_nxt = S_IDLE;
            end
            S_CHECK: begin
                state_nxt = accept ? S_INSERT : S_IDLE;
            end
            S_INSERT: begin
                if (i_deck_done)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_draw     = (state == S_DRAW) ? code : 3'b000;
        o_play_ok  = (state == S_CHECK) && accept;
        o_play_err = (state == S_CHECK) && !accept;
        o_insert   = (state == S_INSERT) && i_deck_done;
        o_busy     = (state != S_IDLE);
    end

    assign o_rd_card   = rd_card;
    assign o_count     = count;
    assign o_prev_card = prev_card;
    assign o_overflow  = overflow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < MAX_CARDS; i++)
                slots[i] <= EMPTY;
            count     <= '0;
            idx       <= '0;
            need      <= '0;
            code      <= '0;
            prev_card <= EMPTY;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        need <= req_need;
                        code <= i_req_draw;
                    end else if (i_play) begin
                        idx <= i_play_idx;
                    end
                end
                S_DRAW: begin
                    if (i_drawn) begin
                        need <= need - 3'd1;
                        if (!full) begin
                            for (int unsigned i = 0; i < MAX_CARDS; i++)
                                if (IDX_W'(i) == count)
                                    slots[i] <= i_card;
                            count <= count + ONE;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    // Swap-with-last compaction; the clear wins when idx is the last slot.
                    if (accept) begin
                        for (int unsigned i = 0; i < MAX_CARDS; i++) begin
                            if (IDX_W'(i) == count_m1)
                                slots[i] <= EMPTY;
                            else if (IDX_W'(i) == idx)
                                slots[i] <= last_card;
                        end
                        count     <= count_m1;
                        prev_card <= sel_card;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HAND_COLOR_CNT_EN
    logic [IDX_W-1:0] color_cnt [4];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned c = 0; c < 4; c++)
                color_cnt[c] <= '0;
        end else if (store) begin
            color_cnt[i_card[5:4]] <= color_cnt[i_card[5:4]] + ONE;
        end else if ((state == S_CHECK) && accept) begin
            color_cnt[sel_card[5:4]] <= color_cnt[sel_card[5:4]] - ONE;
        end
    end

    assign o_color_cnt = {color_cnt[3], color_cnt[2], color_cnt[1], color_cnt[0]};
`else
    logic unused_store;
    assign unused_store = store;
`endif

endmodule
